// File: rtl/slow_clk_meter_pkg.sv
// Shared definitions for the slow-clock meter: FSM state encoding and default sizing.
package slow_clk_meter_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_MEAS = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam int DEF_CNT_W       = 24;
    localparam int DEF_TIMEOUT     = 2000000;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TOL         = 0;

endpackage

// File: rtl/slow_clk_meter_sync_edge_det.sv
// Multi-flop synchroniser plus one history flop; emits rise/fall pulses and the synced level.
// Flops reset to RST_VAL so an input already at that level is not seen as an edge.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/slow_clk_meter.sv
// Measures period, high time, lock and loss-of-signal of a slow async square wave in clk_in cycles.
// Optional duty measurement (hcnt/hi_cap, high_time) is built when SLOW_CLK_METER_DUTY_EN is defined.
module slow_clk_meter
    import slow_clk_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TOL         = DEF_TOL
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic             edge_rise,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic sig_rise;
`ifdef SLOW_CLK_METER_DUTY_EN
    logic sig_fall;
    logic sig_level;
`else
    logic unused_fall;
    logic unused_level;
`endif

    sync_edge_det #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk_in),
        .rst   (rst),
        .din   (sig_in),
        .rise  (sig_rise),
`ifdef SLOW_CLK_METER_DUTY_EN
        .fall  (sig_fall),
        .level (sig_level)
`else
        .fall  (unused_fall),
        .level (unused_level)
`endif
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             edge_rise_q, edge_rise_d;
    logic [CNT_W:0]   diff;

`ifdef SLOW_CLK_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
`endif

    // Extra bit keeps |cnt - prev| exact for any pair of CNT_W values.
    always_comb begin
        if (cnt_q >= prev_q) diff = {1'b0, cnt_q} - {1'b0, prev_q};
        else                 diff = {1'b0, prev_q} - {1'b0, cnt_q};
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        edge_rise_d  = sig_rise;
`ifdef SLOW_CLK_METER_DUTY_EN
        high_time_d  = high_time_q;
`endif
        case (state_q)
            S_WAIT: begin
                cnt_d = '0;
                if (sig_rise) begin
                    state_d   = S_MEAS;
                    cnt_d     = ONE_C;
                    timeout_d = 1'b0;
                end
            end
            S_MEAS, S_RUN: begin
                // A rise on the same cycle cnt hits TIMEOUT is a valid measurement.
                if (sig_rise) begin
                    period_d     = cnt_q;
                    meas_valid_d = 1'b1;
                    cnt_d        = ONE_C;
                    prev_d       = cnt_q;
                    locked_d     = (state_q == S_RUN) && (diff <= TOL_C);
                    state_d      = S_RUN;
`ifdef SLOW_CLK_METER_DUTY_EN
                    high_time_d  = hi_cap_q;
`endif
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    state_d   = S_WAIT;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            prev_q       <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            edge_rise_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
            edge_rise_q  <= edge_rise_d;
        end
    end

`ifdef SLOW_CLK_METER_DUTY_EN
    // hcnt saturates so a stuck-high input cannot wrap it.
    always_comb begin
        hcnt_d   = hcnt_q;
        hi_cap_d = hi_cap_q;
        if (sig_rise)                              hcnt_d = ONE_C;
        else if (sig_level && hcnt_q != TIMEOUT_C) hcnt_d = hcnt_q + ONE_C;
        if (sig_fall) hi_cap_d = hcnt_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            hcnt_q      <= '0;
            hi_cap_q    <= '0;
            high_time_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            hi_cap_q    <= hi_cap_d;
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`else
    assign high_time = '0;
`endif

    assign edge_rise  = edge_rise_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_slow_clk_meter.sv
// Directed bench for slow_clk_meter: table of clk-aligned input periods plus hand sequences
// for reset, loss of signal and a rise coinciding with the timeout count.
module tb_slow_clk_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 5000;
`ifdef SLOW_CLK_METER_DUTY_EN
    localparam int DUTY = 1;
`else
    localparam int DUTY = 0;
`endif

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic             sig_in = 1'b0;
    logic             edge_rise;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    always #5 clk_in = ~clk_in;

    slow_clk_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (2),
        .TOL         (1)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .edge_rise  (edge_rise),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    typedef struct {
        int h;
        int l;
        int exp_mv;
        int exp_period;
        int exp_high;
        int exp_locked;
    } vec_t;

    vec_t vecs[12];

    int errors = 0;
    int checks = 0;
    int mv_cnt = 0;
    int er_cnt = 0;
    int to_seen = 0;
    logic [CNT_W-1:0] cap_period = '0;
    logic [CNT_W-1:0] cap_high = '0;
    logic             cap_locked = 1'b0;

    always @(negedge clk_in) begin
        if (meas_valid) begin
            mv_cnt++;
            cap_period = period;
            cap_high   = high_time;
            cap_locked = locked;
        end
        if (edge_rise) er_cnt++;
        if (timeout) to_seen++;
    end

    function automatic int hexp(input int h);
        return h * DUTY;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mv_cnt  = 0;
        er_cnt  = 0;
        to_seen = 0;
    endtask

    // Called just after a posedge; sig_in is sampled high for exactly h edges, low for l.
    task automatic drive_period(input int h, input int l);
        #1 sig_in = 1'b1;
        repeat (h) @(posedge clk_in);
        #1 sig_in = 1'b0;
        repeat (l) @(posedge clk_in);
    endtask

    task automatic set_vec(input int i, input int h, input int l, input int mv,
                           input int p, input int hi, input int lk);
        vecs[i].h          = h;
        vecs[i].l          = l;
        vecs[i].exp_mv     = mv;
        vecs[i].exp_period = p;
        vecs[i].exp_high   = hi;
        vecs[i].exp_locked = lk;
    endtask

    initial begin
        int k;
        // Each row's checks describe the measurement reported by the rise that starts the row.
        set_vec(0,  500, 500, 0,    0,         0,   0);
        set_vec(1,  500, 500, 1, 1000, hexp(500),   0);
        set_vec(2,  500, 500, 1, 1000, hexp(500),   1);
        set_vec(3,  600, 600, 1, 1000, hexp(500),   1);
        set_vec(4,  600, 600, 1, 1200, hexp(600),   0);
        set_vec(5,  300, 700, 1, 1200, hexp(600),   1);
        set_vec(6,  300, 701, 1, 1000, hexp(300),   0);
        set_vec(7,  300, 700, 1, 1001, hexp(300),   1);
        set_vec(8,  300, 702, 1, 1000, hexp(300),   1);
        set_vec(9,  300, 700, 1, 1002, hexp(300),   0);
        set_vec(10, 500, 500, 1, 1000, hexp(300),   0);
        set_vec(11, 500, 500, 1, 1000, hexp(500),   1);

        rst = 1'b1;
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        check("reset period", period, 0);
        check("reset high_time", high_time, 0);
        check("reset meas_valid", meas_valid, 0);
        check("reset locked", locked, 0);
        check("reset timeout", timeout, 0);
        check("reset edge_rise", edge_rise, 0);
        @(posedge clk_in);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk_in);

        for (int i = 0; i < 12; i++) begin
            clear_mon();
            drive_period(vecs[i].h, vecs[i].l);
            check($sformatf("row%0d edge_rise count", i), er_cnt, 1);
            check($sformatf("row%0d meas_valid count", i), mv_cnt, vecs[i].exp_mv);
            check($sformatf("row%0d timeout", i), to_seen, 0);
            if (vecs[i].exp_mv != 0) begin
                check($sformatf("row%0d period", i), cap_period, vecs[i].exp_period);
                check($sformatf("row%0d high_time", i), cap_high, vecs[i].exp_high);
                check($sformatf("row%0d locked", i), cap_locked, vecs[i].exp_locked);
            end
        end

        // Loss of signal: one last rise, then the input stops toggling.
        #1 sig_in = 1'b1;
        k = 0;
        while (!edge_rise && k < 10) begin
            @(negedge clk_in);
            k++;
        end
        check("los edge_rise seen", edge_rise, 1);
        check("los last meas_valid", meas_valid, 1);
        check("los last period", period, 1000);
        check("los last locked", locked, 1);
        k = 0;
        while (k < 6000) begin
            @(negedge clk_in);
            k++;
            if (k == 500) sig_in = 1'b0;
            if (timeout) break;
        end
        check("los timeout delay", k, TIMEOUT);
        check("los timeout level", timeout, 1);
        check("los locked dropped", locked, 0);
        check("los period kept", period, 1000);
        check("los high_time kept", high_time, hexp(500));

        // Recovery: first rise clears timeout without a measurement.
        @(posedge clk_in);
        clear_mon();
        drive_period(500, 500);
        check("recover edge_rise count", er_cnt, 1);
        check("recover no meas_valid", mv_cnt, 0);
        check("recover timeout cleared", timeout, 0);
        clear_mon();
        drive_period(500, 500);
        check("recover2 meas_valid count", mv_cnt, 1);
        check("recover2 period", cap_period, 1000);
        check("recover2 locked", cap_locked, 0);
        clear_mon();
        drive_period(2500, 2500);
        check("pre-edge meas_valid count", mv_cnt, 1);
        check("pre-edge locked", cap_locked, 1);

        // Period equal to TIMEOUT: the rise lands on cnt==TIMEOUT and must win.
        clear_mon();
        drive_period(500, 500);
        check("edge meas_valid count", mv_cnt, 1);
        check("edge period", cap_period, TIMEOUT);
        check("edge high_time", cap_high, hexp(2500));
        check("edge locked", cap_locked, 0);
        check("edge no timeout", to_seen, 0);

        // Reset while sig_in is high and a measurement is in progress.
        #1 sig_in = 1'b1;
        repeat (20) @(posedge clk_in);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("midrst period", period, 0);
        check("midrst high_time", high_time, 0);
        check("midrst locked", locked, 0);
        check("midrst timeout", timeout, 0);
        check("midrst meas_valid", meas_valid, 0);
        @(posedge clk_in);
        #1 rst = 1'b0;
        clear_mon();
        repeat (50) @(posedge clk_in);
        check("midrst held high no edge", er_cnt, 0);
        check("midrst held high no meas", mv_cnt, 0);
        #1 sig_in = 1'b0;
        repeat (10) @(posedge clk_in);
        #1 sig_in = 1'b1;
        repeat (10) @(posedge clk_in);
        check("midrst new edge", er_cnt, 1);
        check("midrst new edge no meas", mv_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slow_clk_meter.md
# slow_clk_meter

Measures a slow square-wave input (e.g. the divided clock produced elsewhere in the design) in units of the fast system clock. It synchronises the input, detects edges, and reports the period and high time of every cycle. It also reports lock and loss-of-signal status. It is the receiving end of the slow-clock path, used for on-board self-check and for frequency readout on the display/UART logic.

## Interface
- CNT_W, 24: width of period/high-time counters.
- TIMEOUT, 2000000: clk_in cycles without a rising edge before loss-of-signal; must be < 2^CNT_W.
- SYNC_STAGES, 2: synchroniser depth, 2..4.
- TOL, 0: allowed |period difference| in cycles for lock.

Ports:
- clk_in  in  1  fast clock.
- rst  in  1  reset, synchronous, active-high.
- sig_in  in  1  asynchronous slow square wave.
- edge_rise  out  1  one-cycle pulse per detected rising edge.
- period  out  CNT_W  clk_in cycles between the last two rising edges.
- high_time  out  CNT_W  clk_in cycles sig_in was high in the last complete cycle.
- meas_valid  out  1  one-cycle pulse when period/high_time update.
- locked  out  1  consecutive periods agree within TOL.
- timeout  out  1  level: no rising edge for TIMEOUT cycles.

## Operation
- **Synchroniser and edge detect.** sig_in passes through SYNC_STAGES flops, then one history flop. rise = sync & ~hist; fall = ~sync & hist.
- **Reset.** Synchroniser and history flops reset to 1, so a sig_in already high at reset release is not a rising edge. All outputs reset to 0; cnt, hcnt and prev_period reset to 0; FSM resets to S_WAIT.
- **S_WAIT** (after reset or timeout): cnt held at 0. On rise, go to S_MEAS: cnt<=1, hcnt<=1, timeout<=0, no meas_valid.
- **S_MEAS / S_RUN:** cnt increments each cycle. On rise:
  - period<=cnt, meas_valid<=1, cnt<=1, hcnt<=1, prev_period<=cnt.
  - In S_RUN, locked<=(|cnt−prev_period|≤TOL); S_MEAS always goes to S_RUN with locked=0.
- **High-time counter.** hcnt increments while sync is high; it is frozen at fall into hi_cap.
- **Timeout.** cnt reaching TIMEOUT with no rise: timeout<=1, locked<=0, FSM to S_WAIT. period and high_time keep their last values.
- **Rise coincident with cnt==TIMEOUT:** the rise wins; it is a normal measurement and there is no timeout.
- **Width rule.** Period arithmetic is unsigned CNT_W. The difference is computed in CNT_W+1 bits. cnt never exceeds TIMEOUT, so there is no wrap.
- **edge_rise** pulses on every detected rise, in all states.

## Timing
- **Edge-detect latency.** sig_in first sampled high at clk_in edge k → rise is combinationally high after edge k+SYNC_STAGES−1. edge_rise, period, high_time, meas_valid and locked are registered, valid after edge k+SYNC_STAGES.
- **Period resolution.** period equals the true period ±1 cycle of synchroniser jitter. With a constant-period clk_in-synchronous input it is exact.
- **Pulse widths.** meas_valid and edge_rise are exactly one cycle. There is at most one meas_valid per input period.
- **Timeout assertion.** timeout asserts at the edge where cnt would become TIMEOUT, i.e. TIMEOUT cycles after the last rise was registered.

## Configuration
- **SLOW_CLK_METER_DUTY_EN defined:**
  - hcnt/hi_cap logic present.
  - high_time updates alongside period on meas_valid.
  - A fall with no following rise before timeout is discarded.
- **Undefined:**
  - high_time tied to 0.
  - No fall detection or hcnt flops.

## Structure
- **Shared package:** FSM state encoding (S_WAIT, S_MEAS, S_RUN) and default constants (CNT_W, TIMEOUT, SYNC_STAGES).
- **Sub-module sync_edge_det:** parameterised synchroniser plus history flop, outputs rise/fall/level. It is reusable for buttons and other async inputs.

## Test plan
- **Steady input:** 500 high/500 low, clk_in-aligned → meas_valid on 2nd rise with period=1000, locked=0; on 3rd rise period=1000, locked=1.
- **Period change:** 1000→1200 → meas_valid with period=1200 and locked=0 that cycle; locked=1 on next rise.
- **Loss of signal:** TIMEOUT=5000, stop toggling after lock → timeout=1 and locked=0 exactly 5000 cycles after the last edge_rise. Next rise clears timeout with no meas_valid; the following rise gives meas_valid.
- **Reset mid-measurement with sig_in high** → all outputs 0, no edge_rise until sig_in goes low then high.
- **Duty:** 300 high/700 low → high_time=300, period=1000 with SLOW_CLK_METER_DUTY_EN; high_time=0 without.
- **Jitter tolerance:** TOL=1, periods alternating 1000/1001 → locked stays 1. With 1000/1002, locked drops on the mismatching rise.
